// File: rtl/writeback_unit.sv
// ============================================================================
//  Module   : writeback_unit
//  Brief    : Writeback stage driving the register-file write port; ALU results
//             are written directly, loads fetch data over a req/ack handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_unit #(
    parameter int DW         = 16,
    parameter int RAW        = 3,
    parameter int LD_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_is_ld,
    input  logic [RAW-1:0]      ex_dst,
    input  logic [DW-1:0]       ex_result,
    output logic                mem_req,
    output logic [DW-1:0]       mem_addr,
    input  logic                mem_ack,
    input  logic [DW-1:0]       mem_rdata,
    output logic                rf_we,
    output logic [RAW-1:0]      rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic [2**RAW-1:0]   busy_mask,
    output logic                ld_err
);

    localparam int NREG = 2**RAW;
    localparam int CW   = $clog2(LD_TIMEOUT + 1);
    localparam logic [CW-1:0]   c_cnt_last = CW'(LD_TIMEOUT - 1);
    localparam logic [NREG-1:0] c_one_hot0 = {{(NREG-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALU_WB = 2'd1,
        S_LD_REQ = 2'd2,
        S_LD_WB  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_req;
    logic [DW-1:0]     r_addr;
    logic              r_we;
    logic [RAW-1:0]    r_waddr;
    logic [DW-1:0]     r_wdata;
    logic [NREG-1:0]   r_busy;
    logic              r_err;
    logic [CW-1:0]     r_cnt;
    logic [RAW-1:0]    r_dst;

    // S_LD_WB also covers the abort-report cycle: rf_we stays low, ld_err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_dst   <= '0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (ex_valid) begin
                        r_dst   <= ex_dst;
                        r_busy  <= c_one_hot0 << ex_dst;
                        r_ready <= 1'b0;
                        if (ex_is_ld) begin
                            r_state <= S_LD_REQ;
                            r_req   <= 1'b1;
                            r_addr  <= ex_result;
                        end else begin
                            r_state <= S_ALU_WB;
                            r_we    <= 1'b1;
                            r_waddr <= ex_dst;
                            r_wdata <= ex_result;
                        end
                    end
                end
                S_LD_REQ: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (mem_ack) begin
                        r_state <= S_LD_WB;
                        r_req   <= 1'b0;
                        r_we    <= 1'b1;
                        r_waddr <= r_dst;
                        r_wdata <= mem_rdata;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= S_LD_WB;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_cnt   <= r_cnt + CW'(1);
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                S_ALU_WB, S_LD_WB: begin
                    r_state <= S_IDLE;
                    r_busy  <= '0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= '0;
                    r_ready <= 1'b1;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign ex_ready  = r_ready;
    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign busy_mask = r_busy;
    assign ld_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
//  Module   : tb_writeback_unit
//  Brief    : Directed self-checking bench for writeback_unit with a
//             transaction-level reference model compared every cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;

    localparam int DW = 16;
    localparam int RAW = 3;
    localparam int T = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ex_valid = 1'b0;
    logic           ex_ready;
    logic           ex_is_ld = 1'b0;
    logic [RAW-1:0] ex_dst = '0;
    logic [DW-1:0]  ex_result = '0;
    logic           mem_req;
    logic [DW-1:0]  mem_addr;
    logic           mem_ack = 1'b0;
    logic [DW-1:0]  mem_rdata = '0;
    logic           rf_we;
    logic [RAW-1:0] rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic [7:0]     busy_mask;
    logic           ld_err;

    int checks = 0;
    int failures = 0;

    writeback_unit #(.DW(DW), .RAW(RAW), .LD_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_ld(ex_is_ld),
        .ex_dst(ex_dst), .ex_result(ex_result),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding instruction, tracked by its age and outcome.
    bit             m_started = 0;
    bit             m_active = 0;
    bit             m_is_ld = 0;
    int             m_dst = 0;
    int             m_age = 0;
    int             m_finish = 0;
    logic           e_ready = 1'b1, e_req = 1'b0, e_we = 1'b0, e_err = 1'b0;
    logic [DW-1:0]  e_addr = '0, e_wdata = '0;
    logic [RAW-1:0] e_waddr = '0;
    logic [7:0]     e_busy = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1;
            m_active = 0; m_finish = 0; m_age = 0;
            e_addr = '0; e_we = 0; e_waddr = '0; e_wdata = '0; e_err = 0;
        end else begin
            e_we = 0;
            e_err = 0;
            if (m_active && m_finish != 0) begin
                m_active = 0;
                m_finish = 0;
            end else if (m_active) begin
                m_age++;
                if (mem_ack) begin
                    m_finish = 1;
                    e_we = 1; e_waddr = RAW'(m_dst); e_wdata = mem_rdata;
                end else if (m_age == T) begin
                    m_finish = 2;
                    e_err = 1;
                end
            end else if (ex_valid) begin
                m_active = 1;
                m_is_ld = ex_is_ld;
                m_dst = int'(ex_dst);
                m_age = 0;
                if (ex_is_ld) begin
                    m_finish = 0;
                    e_addr = ex_result;
                end else begin
                    m_finish = 1;
                    e_we = 1; e_waddr = ex_dst; e_wdata = ex_result;
                end
            end
        end
        e_ready = !m_active;
        e_req   = m_active && m_is_ld && m_finish == 0;
        e_busy  = m_active ? 8'(1 << m_dst) : 8'h00;
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("model_ex_ready", 32'(ex_ready), 32'(e_ready));
            chk("model_mem_req", 32'(mem_req), 32'(e_req));
            chk("model_mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("model_rf_we", 32'(rf_we), 32'(e_we));
            chk("model_rf_waddr", 32'(rf_waddr), 32'(e_waddr));
            chk("model_rf_wdata", 32'(rf_wdata), 32'(e_wdata));
            chk("model_busy_mask", 32'(busy_mask), 32'(e_busy));
            chk("model_ld_err", 32'(ld_err), 32'(e_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic is_ld, input logic [RAW-1:0] dst, input logic [DW-1:0] res);
        ex_valid = 1'b1; ex_is_ld = is_ld; ex_dst = dst; ex_result = res;
        tick();
        ex_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [RAW-1:0] bp_dst [3];
        logic [DW-1:0]  bp_res [3];
        bp_dst[0] = 3'd1; bp_dst[1] = 3'd7; bp_dst[2] = 3'd0;
        bp_res[0] = 16'h1111; bp_res[1] = 16'h7777; bp_res[2] = 16'hA0A0;

        tick(); tick();
        rst = 1'b0;
        chk("reset_ready", 32'(ex_ready), 32'd1);
        chk("reset_busy", 32'(busy_mask), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_wdata", 32'(rf_wdata), 32'd0);

        // ALU op
        issue(1'b0, 3'd3, 16'h1234);
        chk("alu_we", 32'(rf_we), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd3);
        chk("alu_wdata", 32'(rf_wdata), 32'h1234);
        chk("alu_busy", 32'(busy_mask), 32'h08);
        chk("alu_ready_low", 32'(ex_ready), 32'd0);
        tick();
        chk("alu_ready_back", 32'(ex_ready), 32'd1);
        chk("alu_busy_clear", 32'(busy_mask), 32'd0);

        // Load acked in its third request cycle
        issue(1'b1, 3'd5, 16'h0040);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            chk("ld_addr", 32'(mem_addr), 32'h0040);
            if (n == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
            tick();
            mem_ack = 1'b0;
        end
        chk("ld_req_cycles", 32'(n), 32'd3);
        chk("ld_we", 32'(rf_we), 32'd1);
        chk("ld_waddr", 32'(rf_waddr), 32'd5);
        chk("ld_wdata", 32'(rf_wdata), 32'hBEEF);
        chk("ld_busy", 32'(busy_mask), 32'h20);
        tick();
        chk("ld_addr_hold", 32'(mem_addr), 32'h0040);

        // Stray acks while idle, then same-cycle ack
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        chk("idle_ack_no_we", 32'(rf_we), 32'd0);
        mem_ack = 1'b0;
        issue(1'b1, 3'd2, 16'h0100);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        chk("fast_req", 32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("fast_req_drop", 32'(mem_req), 32'd0);
        chk("fast_wdata", 32'(rf_wdata), 32'hCAFE);
        chk("fast_waddr", 32'(rf_waddr), 32'd2);
        tick();

        // Timeout: no ack ever
        issue(1'b1, 3'd6, 16'h0200);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_req_cycles", 32'(n), 32'd15);
        chk("to_err", 32'(ld_err), 32'd1);
        chk("to_busy", 32'(busy_mask), 32'h40);
        chk("to_no_we", 32'(rf_we), 32'd0);
        tick();
        chk("to_err_pulse", 32'(ld_err), 32'd0);
        chk("to_busy_clear", 32'(busy_mask), 32'd0);
        chk("to_ready", 32'(ex_ready), 32'd1);

        // Ack on the final allowed request cycle beats the timeout
        issue(1'b1, 3'd1, 16'h0300);
        for (int i = 1; i < T; i++) tick();
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        chk("edge_req", 32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("edge_we", 32'(rf_we), 32'd1);
        chk("edge_err", 32'(ld_err), 32'd0);
        chk("edge_wdata", 32'(rf_wdata), 32'h5A5A);
        tick();

        // Reset mid-load
        issue(1'b1, 3'd4, 16'h0400);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy_mask), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0;
        chk("rst_late_ack", 32'(rf_we), 32'd0);
        tick();

        // Back-pressure: ex_valid held across three ALU ops
        ex_valid = 1'b1; ex_is_ld = 1'b0;
        ex_dst = bp_dst[0]; ex_result = bp_res[0];
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_we", 32'(rf_we), 32'd1);
            chk("bp_waddr", 32'(rf_waddr), 32'(bp_dst[k]));
            chk("bp_wdata", 32'(rf_wdata), 32'(bp_res[k]));
            chk("bp_ready_low", 32'(ex_ready), 32'd0);
            if (k < 2) begin
                ex_dst = bp_dst[k+1]; ex_result = bp_res[k+1];
            end else begin
                ex_valid = 1'b0;
            end
            tick();
            chk("bp_gap_we", 32'(rf_we), 32'd0);
            if (k < 2) tick();
        end
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
